// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared register-bank write arbiter.
package shared_reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_e;

  localparam int MAX_N_REQ = 8;
  localparam int MAX_DEPTH = 32;

  // Wrap-around increment over 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester write ports, clear control and read port of the shared register bank.
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [N_REQ-1:0]        req_valid_in;
  logic [N_REQ*ADDR_W-1:0] req_addr_in;
  logic [N_REQ*WIDTH-1:0]  req_data_in;
  logic [N_REQ-1:0]        req_ready_out;
  logic                    clr_in;
  logic                    busy_out;
  logic [ADDR_W-1:0]       rd_addr_in;
  logic [WIDTH-1:0]        rd_data_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_data_in, clr_in, rd_addr_in,
    output req_ready_out, busy_out, rd_data_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_data_in, clr_in, rd_addr_in,
    input  req_ready_out, busy_out, rd_data_out
  );

endinterface

// File: rtl/register.sv
// Single bank entry: write-enabled storage word with an async active-low clear.
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_in,
  input  logic             we_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge arst_n_in) begin
    if (!arst_n_in) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q <= din_i;
    end
  end

  assign dout_o = data_q;

endmodule

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating picker: first valid index after last_i, as one-hot and index.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = last_i;
    for (int k = 0; k < N; k++) begin
      cand = IW'(rr_next(32'(cand), N));
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter, one-cycle write pipeline and sequential clear for a shared register bank.
// SHARED_REG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WIDTH  = 20,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst_in,
  shared_reg_arbiter_if.slave bus
);

  localparam int         IW      = $clog2(N_REQ);
  localparam logic [0:0] S_IDLE  = ARB_IDLE;
  localparam logic [0:0] S_CLEAR = ARB_CLEAR;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_pend_v_q, wr_pend_v_d;
  logic [ADDR_W-1:0] wr_pend_addr_q, wr_pend_addr_d;
  logic [WIDTH-1:0]  wr_pend_dat_q, wr_pend_dat_d;

  logic [IW-1:0]     rr_last;
  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              arb_en;
  logic [N_REQ-1:0]  grant;
  logic              accept;

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
  assign rr_last = IW'(N_REQ - 1);
`else
  logic [IW-1:0] last_grant_q, last_grant_d;

  assign last_grant_d = accept ? pick_idx : last_grant_q;
  assign rr_last      = last_grant_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      last_grant_q <= IW'(N_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (bus.req_valid_in),
    .last_i  (rr_last),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // A clear request in IDLE wins over every requester in that cycle.
  assign arb_en            = (state_q == S_IDLE) && !bus.clr_in && !rst_in;
  assign grant             = arb_en ? pick_grant : '0;
  assign accept            = |grant;
  assign bus.req_ready_out = grant;
  assign bus.busy_out      = (state_q == S_CLEAR);

  always_comb begin
    state_d        = state_q;
    clr_ptr_d      = clr_ptr_q;
    wr_pend_v_d    = accept;
    wr_pend_addr_d = wr_pend_addr_q;
    wr_pend_dat_d  = wr_pend_dat_q;
    if (accept) begin
      wr_pend_addr_d = bus.req_addr_in[pick_idx*ADDR_W +: ADDR_W];
      wr_pend_dat_d  = bus.req_data_in[pick_idx*WIDTH +: WIDTH];
    end
    case (state_q)
      S_IDLE: begin
        if (bus.clr_in) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      clr_ptr_q   <= '0;
      wr_pend_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_pend_v_q <= wr_pend_v_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_pend_addr_q <= wr_pend_addr_d;
    wr_pend_dat_q  <= wr_pend_dat_d;
  end

  logic [WIDTH-1:0] bank_q [DEPTH];

  // Reset and clear both zero entries through the write path; no async reset is used.
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    logic clr_hit, wr_hit, zero_wr;

    assign clr_hit = (state_q == S_CLEAR) && (clr_ptr_q == ADDR_W'(i));
    assign wr_hit  = wr_pend_v_q && (wr_pend_addr_q == ADDR_W'(i));
    assign zero_wr = rst_in | clr_hit;

    register #(.WIDTH(WIDTH)) u_reg (
      .clk_i     (clk),
      .arst_n_in (1'b1),
      .we_i      (zero_wr | wr_hit),
      .din_i     (zero_wr ? '0 : wr_pend_dat_q),
      .dout_o    (bank_q[i])
    );
  end

  assign bus.rd_data_out = bank_q[bus.rd_addr_in];

endmodule
